// File: rtl/prime_factor.sv
// prime_factor: iterative primality tester and smallest-prime-factor finder.
// Screens the trivial cases first, then tries odd divisors d = 3, 5, 7, ...
// while d*d <= n. Each trial division is a restoring remainder loop that
// handles one bit of n per cycle. d*d is tracked incrementally in sq, so the
// unit needs no multiplier and no combinational divider.
module prime_factor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] sw,
  output logic             busy,
  output logic             stp,
  output logic             res,
  output logic [WIDTH-1:0] factor
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    TEST  = 3'd2,
    DIV   = 3'd3,
    EVAL  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [2*WIDTH-1:0]   sq_q, sq_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 stp_q, stp_d;
  logic                 res_q, res_d;
  logic [WIDTH-1:0]     factor_q, factor_d;

  // Datapath helpers for the remainder step and the square update.
  logic [WIDTH-1:0]     n_shift;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       d_ext;
  logic [2*WIDTH-1:0]   sq_next;
  logic [2*WIDTH-1:0]   n_wide;

  assign n_shift   = n_q >> (cnt_q - CNT_ONE);
  assign rem_shift = {rem_q[WIDTH-1:0], n_shift[0]};
  assign d_ext     = {1'b0, d_q};
  // (d+2)^2 = d^2 + 4d + 4
  assign sq_next   = sq_q + ({{WIDTH{1'b0}}, d_q} << 2) + (2*WIDTH)'(4);
  assign n_wide    = {{WIDTH{1'b0}}, n_q};

  // Next-state and next-output logic for the whole FSM.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    sq_d     = sq_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    stp_d    = stp_q;
    res_d    = res_q;
    factor_d = factor_q;

    case (state_q)
      IDLE, DONE: begin
        // Trivial results arrive here still busy; flag them done one edge later.
        if (state_q == DONE && busy_q) begin
          busy_d = 1'b0;
          stp_d  = 1'b1;
        end
        if (go && !busy_q) begin
          n_d      = sw;
          state_d  = CHECK;
          busy_d   = 1'b1;
          stp_d    = 1'b0;
          res_d    = 1'b0;
          factor_d = '0;
        end
      end

      CHECK: begin
        state_d = DONE;
        if (n_q < WIDTH'(2)) begin
          res_d    = 1'b1;
          factor_d = '0;
        end else if (n_q < WIDTH'(4)) begin
          res_d    = 1'b0;
          factor_d = n_q;
        end else if (!n_q[0]) begin
          res_d    = 1'b1;
          factor_d = WIDTH'(2);
        end else begin
          d_d     = WIDTH'(3);
          sq_d    = (2*WIDTH)'(9);
          state_d = TEST;
        end
      end

      TEST: begin
        if (sq_q > n_wide) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          stp_d    = 1'b1;
          res_d    = 1'b0;
          factor_d = n_q;
        end else begin
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = DIV;
        end
      end

      DIV: begin
        rem_d = (rem_shift >= d_ext) ? (rem_shift - d_ext) : rem_shift;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = EVAL;
        end
      end

      EVAL: begin
        if (rem_q == '0) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          stp_d    = 1'b1;
          res_d    = 1'b1;
          factor_d = d_q;
        end else begin
          sq_d    = sq_next;
          d_d     = d_q + WIDTH'(2);
          state_d = TEST;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any test in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      d_q      <= '0;
      sq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      stp_q    <= 1'b0;
      res_q    <= 1'b0;
      factor_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      sq_q     <= sq_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      stp_q    <= stp_d;
      res_q    <= res_d;
      factor_q <= factor_d;
    end
  end

  assign busy   = busy_q;
  assign stp    = stp_q;
  assign res    = res_q;
  assign factor = factor_q;

endmodule
